// File: rtl/dcache_flush_unit.sv
`default_nettype none
// ============================================================================
// Module   : dcache_flush_unit
// Purpose  : Responder side of the dcache flush handshake. On a flush request
//            it walks every set of the write-back dcache, reads the tags,
//            writes back every valid+dirty way (lowest way first) and then
//            invalidates all ways of the set. It finishes with a one-cycle
//            acknowledge, followed by one cycle in which a still-high request
//            is ignored.
// Ports    : clk_i / rst_ni      clock, asynchronous active-low reset
//            flush_i / flush_ack_o  level request in, one-cycle ack out
//            busy_o              high whenever the walker is not idle
//            tag_*               tag-array port (read = 0, invalidate = 1)
//            valid_i / dirty_i   line state, returned with tag_rdata_i
//            wb_*                writeback request/response to the miss unit
// Revision : 1.0 - initial release
// ============================================================================
module dcache_flush_unit #(
    parameter int  NR_SETS   = 256,
    parameter int  NR_WAYS   = 8,
    parameter int  TAG_WIDTH = 44,
    parameter int  OFFSET_W  = 4,
    localparam int INDEX_W   = $clog2(NR_SETS),
    localparam int WAY_W     = $clog2(NR_WAYS),
    localparam int ADDR_W    = TAG_WIDTH + INDEX_W + OFFSET_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    output logic                         flush_ack_o,
    output logic                         busy_o,
    output logic                         tag_req_o,
    input  logic                         tag_gnt_i,
    output logic                         tag_we_o,
    output logic [INDEX_W-1:0]           tag_index_o,
    output logic [NR_WAYS-1:0]           tag_way_be_o,
    input  logic [NR_WAYS*TAG_WIDTH-1:0] tag_rdata_i,
    input  logic [NR_WAYS-1:0]           valid_i,
    input  logic [NR_WAYS-1:0]           dirty_i,
    output logic                         wb_valid_o,
    input  logic                         wb_ready_i,
    output logic [ADDR_W-1:0]            wb_addr_o,
    output logic [WAY_W-1:0]             wb_way_o,
    input  logic                         wb_done_i
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_REQ  = 3'd1;
    localparam logic [2:0] c_RD_RSP  = 3'd2;
    localparam logic [2:0] c_WB_REQ  = 3'd3;
    localparam logic [2:0] c_WB_WAIT = 3'd4;
    localparam logic [2:0] c_INV_REQ = 3'd5;
    localparam logic [2:0] c_DONE    = 3'd6;
    localparam logic [2:0] c_HOLD    = 3'd7;

    localparam logic [INDEX_W-1:0] c_LAST_INDEX = INDEX_W'(NR_SETS - 1);

    logic [2:0]                   r_state_q, w_state_d;
    logic [INDEX_W-1:0]           r_index_q, w_index_d;
    logic [NR_WAYS*TAG_WIDTH-1:0] r_tags_q,  w_tags_d;
    logic [NR_WAYS-1:0]           r_pend_q,  w_pend_d;

    logic [WAY_W-1:0]             w_wb_way;
    logic [TAG_WIDTH-1:0]         w_wb_tag;
    logic [NR_WAYS-1:0]           w_pend_left;
    logic [NR_WAYS-1:0]           w_rsp_pend;

    // Lowest pending way: scanning downwards lets the lowest index win.
    always_comb begin
        w_wb_way = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (r_pend_q[w]) begin
                w_wb_way = WAY_W'(w);
            end
        end
    end

    assign w_wb_tag    = r_tags_q[w_wb_way*TAG_WIDTH +: TAG_WIDTH];
    assign w_pend_left = r_pend_q & ~(NR_WAYS'(1) << w_wb_way);
    // Dirty-but-invalid ways carry stale data and must never be written back.
    assign w_rsp_pend  = dirty_i & valid_i;

    // ------------------------------------------------------------------
    // State register and walk datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= c_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_index_q <= '0;
            r_tags_q  <= '0;
            r_pend_q  <= '0;
        end else begin
            r_index_q <= w_index_d;
            r_tags_q  <= w_tags_d;
            r_pend_q  <= w_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_index_d = r_index_q;
        w_tags_d  = r_tags_q;
        w_pend_d  = r_pend_q;
        case (r_state_q)
            c_IDLE: begin
                if (flush_i) begin
                    w_state_d = c_RD_REQ;
                    w_index_d = '0;
                end
            end
            c_RD_REQ: begin
                if (tag_gnt_i) begin
                    w_state_d = c_RD_RSP;
                end
            end
            c_RD_RSP: begin
                w_tags_d  = tag_rdata_i;
                w_pend_d  = w_rsp_pend;
                w_state_d = (|w_rsp_pend) ? c_WB_REQ : c_INV_REQ;
            end
            c_WB_REQ: begin
                if (wb_ready_i) begin
                    w_state_d = c_WB_WAIT;
                end
            end
            c_WB_WAIT: begin
                if (wb_done_i) begin
                    w_pend_d  = w_pend_left;
                    w_state_d = (|w_pend_left) ? c_WB_REQ : c_INV_REQ;
                end
            end
            c_INV_REQ: begin
                if (tag_gnt_i) begin
                    if (r_index_q == c_LAST_INDEX) begin
                        w_state_d = c_DONE;
                    end else begin
                        w_index_d = r_index_q + 1'b1;
                        w_state_d = c_RD_REQ;
                    end
                end
            end
            c_DONE:  w_state_d = c_HOLD;
            // The requester may still show its registered request here.
            c_HOLD:  w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (pure function of registered state)
    // ------------------------------------------------------------------
    always_comb begin
        flush_ack_o  = 1'b0;
        busy_o       = (r_state_q != c_IDLE);
        tag_req_o    = 1'b0;
        tag_we_o     = 1'b0;
        tag_index_o  = '0;
        tag_way_be_o = '0;
        wb_valid_o   = 1'b0;
        wb_addr_o    = '0;
        wb_way_o     = '0;
        case (r_state_q)
            c_RD_REQ: begin
                tag_req_o   = 1'b1;
                tag_index_o = r_index_q;
            end
            c_INV_REQ: begin
                tag_req_o    = 1'b1;
                tag_we_o     = 1'b1;
                tag_index_o  = r_index_q;
                tag_way_be_o = '1;
            end
            c_WB_REQ: begin
                wb_valid_o = 1'b1;
                wb_addr_o  = {w_wb_tag, r_index_q, {OFFSET_W{1'b0}}};
                wb_way_o   = w_wb_way;
            end
            c_DONE: begin
                flush_ack_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_flush_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_flush_unit
// Purpose  : Self-checking bench for dcache_flush_unit. A small cache model
//            answers tag reads and absorbs invalidates; a writeback handler
//            model accepts requests. Expected writebacks are derived from the
//            initial cache contents (every valid+dirty line, set-major, way
//            ascending) and compared against what the DUT actually issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_flush_unit;

    localparam int NS = 4;
    localparam int NW = 2;
    localparam int TW = 8;
    localparam int OW = 4;
    localparam int IW = 2;
    localparam int WW = 1;
    localparam int AW = TW + IW + OW;

    typedef logic [AW+WW-1:0] wbrec_t;   // {tag, index, offset, way}

    typedef struct {
        logic [7:0]  vpat;     // valid bit of set s way w at [s*NW+w]
        logic [7:0]  dpat;     // dirty bits, same layout
        logic [7:0]  tag;
        int          gw;       // grant delay (cycles) per tag request
        int          rw;       // ready delay per writeback request
        int          dd;       // cycles from accept to done
        bit          hold;     // keep flush_i high past the ack
        int          exp_ack;  // cycle of flush_ack_o
        int          exp_nwb;
        wbrec_t      exp_wb0;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic tag_gnt_i = 1'b0;
    logic wb_ready_i = 1'b0;
    logic wb_done_i = 1'b0;
    logic [NW*TW-1:0] tag_rdata_i = '0;
    logic [NW-1:0]    valid_i = '0;
    logic [NW-1:0]    dirty_i = '0;

    logic          flush_ack_o, busy_o, tag_req_o, tag_we_o, wb_valid_o;
    logic [IW-1:0] tag_index_o;
    logic [NW-1:0] tag_way_be_o;
    logic [AW-1:0] wb_addr_o;
    logic [WW-1:0] wb_way_o;

    dcache_flush_unit #(
        .NR_SETS  (NS),
        .NR_WAYS  (NW),
        .TAG_WIDTH(TW),
        .OFFSET_W (OW)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .busy_o      (busy_o),
        .tag_req_o   (tag_req_o),
        .tag_gnt_i   (tag_gnt_i),
        .tag_we_o    (tag_we_o),
        .tag_index_o (tag_index_o),
        .tag_way_be_o(tag_way_be_o),
        .tag_rdata_i (tag_rdata_i),
        .valid_i     (valid_i),
        .dirty_i     (dirty_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_addr_o   (wb_addr_o),
        .wb_way_o    (wb_way_o),
        .wb_done_i   (wb_done_i)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [TW-1:0] m_tag [NS][NW];
    bit            m_val [NS][NW];
    bit            m_dty [NS][NW];
    wbrec_t        exp_q[$];
    wbrec_t        got_q[$];
    bit            busy_hist[$];
    int            nrd, ninv, nack, ack_cyc, ord_err, stab_err, n_done;
    logic [31:0]   abort_outs;
    vec_t          tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_bits();
        return {8'h00, flush_ack_o, busy_o, tag_req_o, tag_we_o, tag_index_o,
                tag_way_be_o, wb_valid_o, wb_addr_o, wb_way_o};
    endfunction

    // Number of expected writebacks belonging to sets 0..s.
    function automatic int exp_wb_upto(input int s);
        int c = 0;
        foreach (exp_q[i]) if (int'(exp_q[i][WW+OW +: IW]) <= s) c++;
        return c;
    endfunction

    task automatic load_pattern(input logic [7:0] vpat, input logic [7:0] dpat, input logic [7:0] tag);
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_tag[s][w] = tag;
                m_val[s][w] = vpat[s*NW+w];
                m_dty[s][w] = dpat[s*NW+w];
            end
    endtask

    task automatic load_random();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_tag[s][w] = TW'($urandom);
                m_val[s][w] = ($urandom_range(0, 1) == 1);
                m_dty[s][w] = ($urandom_range(0, 1) == 1);
            end
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++)
                if (m_val[s][w] && m_dty[s][w])
                    exp_q.push_back({m_tag[s][w], IW'(s), {OW{1'b0}}, WW'(w)});
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; flush_i = 1'b0; tag_gnt_i = 1'b0; wb_ready_i = 1'b0; wb_done_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Drives one flush from cycle 0 (the first cycle flush_i is seen in IDLE).
    task automatic run_flush(input int gw, input int rw, input int dd, input int flush_len,
                             input bit hold, input bit rnd, input bit abort, output bit aborted);
        int gcnt = 0, rcnt = 0, done_cnt = 0, rd_idx = 0;
        bit rd_pend = 0, t_stall = 0, w_stall = 0, armed = 0, g, r;
        logic          p_we = 1'b0;
        logic [IW-1:0] p_idx = '0;
        logic [AW-1:0] p_addr = '0;
        logic [WW-1:0] p_way = '0;
        nrd = 0; ninv = 0; nack = 0; ack_cyc = -1; ord_err = 0; stab_err = 0; n_done = 0;
        aborted = 0; got_q.delete(); busy_hist.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (armed) begin
                rst_ni = 1'b0;
                #1 abort_outs = out_bits();
                aborted = 1;
                break;
            end
            flush_i = (cyc < flush_len) && (hold || nack == 0);
            if (rd_pend) begin
                for (int w = 0; w < NW; w++) begin
                    tag_rdata_i[w*TW +: TW] = m_tag[rd_idx][w];
                    valid_i[w] = m_val[rd_idx][w];
                    dirty_i[w] = m_dty[rd_idx][w];
                end
            end else begin
                tag_rdata_i = (NW*TW)'($urandom);
                valid_i = NW'($urandom);
                dirty_i = NW'($urandom);
            end
            rd_pend = 0;
            wb_done_i = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin wb_done_i = 1'b1; n_done++; end
            end else if (rnd && !wb_valid_o && $urandom_range(0, 3) == 0) begin
                wb_done_i = 1'b1;   // stray completion, must be ignored
            end
            busy_hist.push_back(busy_o);
            if (flush_ack_o) begin nack++; ack_cyc = cyc; end
            // tag-array port
            if (t_stall && (!tag_req_o || tag_we_o !== p_we || tag_index_o !== p_idx)) stab_err++;
            t_stall = 0; tag_gnt_i = 1'b0;
            if (tag_req_o) begin
                g = rnd ? ($urandom_range(0, 2) != 0) : (gcnt >= gw);
                gcnt = g ? 0 : gcnt + 1;
                tag_gnt_i = g; t_stall = !g; p_we = tag_we_o; p_idx = tag_index_o;
                if (g && tag_we_o) begin
                    if (tag_way_be_o !== '1 || tag_index_o !== IW'(ninv) || nrd != ninv + 1 ||
                        done_cnt != 0 || n_done != exp_wb_upto(ninv)) ord_err++;
                    for (int w = 0; w < NW; w++) begin
                        m_val[tag_index_o][w] = 0;
                        m_dty[tag_index_o][w] = 0;
                    end
                    ninv++;
                end else if (g) begin
                    if (tag_way_be_o !== '0 || tag_index_o !== IW'(nrd) || nrd != ninv) ord_err++;
                    nrd++; rd_pend = 1; rd_idx = int'(tag_index_o);
                end
            end
            // writeback port
            if (w_stall && (!wb_valid_o || wb_addr_o !== p_addr || wb_way_o !== p_way)) stab_err++;
            w_stall = 0; wb_ready_i = 1'b0;
            if (wb_valid_o) begin
                if (done_cnt != 0) ord_err++;
                r = rnd ? ($urandom_range(0, 2) == 0) : (rcnt >= rw);
                rcnt = r ? 0 : rcnt + 1;
                wb_ready_i = r; w_stall = !r; p_addr = wb_addr_o; p_way = wb_way_o;
                if (r) begin
                    got_q.push_back({wb_addr_o, wb_way_o});
                    done_cnt = rnd ? int'($urandom_range(1, 3)) : dd;
                    armed = abort;
                end
            end
            if (nack > 0 && cyc >= ack_cyc + 3) break;
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0; tag_gnt_i = 1'b0; wb_ready_i = 1'b0; wb_done_i = 1'b0;
    endtask

    task automatic general_checks(input bit hold, input string id);
        int mm = 0;
        check({id, "_acks"}, nack, 1);
        check({id, "_reads"}, nrd, NS + int'(hold));
        check({id, "_invals"}, ninv, NS);
        check({id, "_order"}, ord_err, 0);
        check({id, "_stable"}, stab_err, 0);
        check({id, "_wb_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mm++;
        check({id, "_wb_seq"}, mm, 0);
        @(negedge clk);
        check({id, "_busy_after"}, busy_o, hold);
    endtask

    initial begin
        bit ab;
        int bad;
        tbl[0] = '{8'h00, 8'h00, 8'h5A, 0, 0, 1, 1'b0, 13, 0, '0};
        tbl[1] = '{8'h20, 8'h20, 8'h5A, 0, 0, 1, 1'b0, 15, 1, {14'h16A0, 1'b1}};
        tbl[2] = '{8'h03, 8'h03, 8'h5A, 0, 0, 1, 1'b0, 17, 2, {14'h1680, 1'b0}};
        tbl[3] = '{8'hF0, 8'h0C, 8'h5A, 0, 0, 1, 1'b0, 13, 0, '0};
        tbl[4] = '{8'h04, 8'h04, 8'h5A, 5, 3, 1, 1'b0, 58, 1, {14'h1690, 1'b0}};
        tbl[5] = '{8'h00, 8'h00, 8'h5A, 0, 0, 1, 1'b1, 13, 0, '0};

        do_reset();
        check("reset_outputs", out_bits(), 32'h0);

        foreach (tbl[i]) begin
            string id;
            id = $sformatf("vec%0d", i);
            do_reset();
            load_pattern(tbl[i].vpat, tbl[i].dpat, tbl[i].tag);
            build_expected();
            run_flush(tbl[i].gw, tbl[i].rw, tbl[i].dd, 100000, tbl[i].hold, 1'b0, 1'b0, ab);
            check({id, "_ack_cycle"}, ack_cyc, tbl[i].exp_ack);
            check({id, "_nwb"}, got_q.size(), tbl[i].exp_nwb);
            if (tbl[i].exp_nwb > 0 && got_q.size() > 0)
                check({id, "_wb_first"}, got_q[0], tbl[i].exp_wb0);
            bad = 0;
            foreach (busy_hist[c]) begin
                bit e;
                e = (c >= 1 && c <= tbl[i].exp_ack + 1) || (tbl[i].hold && c >= tbl[i].exp_ack + 3);
                if (busy_hist[c] !== e) bad++;
            end
            check({id, "_busy_window"}, bad, 0);
            general_checks(tbl[i].hold, id);
        end

        for (int k = 0; k < 8; k++) begin
            do_reset();
            load_random();
            build_expected();
            run_flush(0, 0, 1, int'($urandom_range(1, 80)), 1'b0, 1'b1, 1'b0, ab);
            general_checks(1'b0, $sformatf("rnd%0d", k));
        end

        // Reset while a writeback is outstanding.
        do_reset();
        load_pattern(8'h04, 8'h04, 8'h3C);
        build_expected();
        run_flush(0, 0, 1, 100000, 1'b0, 1'b0, 1'b1, ab);
        check("abort_reached", ab, 1);
        check("abort_outputs", abort_outs, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (flush_ack_o) nack++;
            if (busy_o) bad++;
        end
        check("abort_no_ack", nack, 0);
        check("abort_idle", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_flush_unit.md
Name: dcache_flush_unit

Overview:
- Responder side of the pipeline's dcache flush handshake. Receives the level-held flush request from the flush controller.
- Walks every set of a write-back dcache, writes back dirty lines through the miss/writeback handler, and invalidates every way.
- Returns a single-cycle acknowledge when done.
- Sits inside the dcache, arbitrating for the tag array against the normal load/store ports.

Parameters:
- NR_SETS, 256, number of cache sets (power of 2, >=2); INDEX_W = $clog2(NR_SETS)
- NR_WAYS, 8, associativity (power of 2, >=2); WAY_W = $clog2(NR_WAYS)
- TAG_WIDTH, 44, tag bits per way
- OFFSET_W, 4, byte-offset bits of a line; ADDR_W = TAG_WIDTH+INDEX_W+OFFSET_W

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- flush_i  in  1  flush request, held high by requester until ack
- flush_ack_o  out  1  one-cycle pulse, flush complete
- busy_o  out  1  high whenever state != IDLE; blocks new cache requests
- tag_req_o  out  1  tag-array access request
- tag_gnt_i  in  1  tag-array grant, same cycle as request
- tag_we_o  out  1  1 = invalidate write, 0 = read
- tag_index_o  out  INDEX_W  set index of access
- tag_way_be_o  out  NR_WAYS  per-way write enable (all ones on invalidate, zero on read)
- tag_rdata_i  in  NR_WAYS*TAG_WIDTH  tags, way w at [w*TAG_WIDTH +: TAG_WIDTH]; valid the cycle after read grant
- valid_i  in  NR_WAYS  valid bits, same timing as tag_rdata_i
- dirty_i  in  NR_WAYS  dirty bits, same timing as tag_rdata_i
- wb_valid_o  out  1  writeback request
- wb_ready_i  in  1  writeback handler accepts request
- wb_addr_o  out  ADDR_W  line address {tag, index, OFFSET_W'0}
- wb_way_o  out  WAY_W  way being written back
- wb_done_i  in  1  writeback of the accepted line completed

Behaviour:
- Reset: async, active-low. State=IDLE, index=0, captured tags/dirty mask=0. All outputs 0.
- Reset mid-flush: abandons the walk immediately, no ack issued; cache is left partially flushed, which is legal.
- FSM states: IDLE, RD_REQ, RD_RSP, WB_REQ, WB_WAIT, INV_REQ, DONE, HOLD.
- IDLE: flush_i=1 -> RD_REQ with index=0.
- RD_REQ: tag_req_o=1, tag_we_o=0, tag_index_o=index. On tag_gnt_i -> RD_RSP; otherwise stay, request held stable.
- RD_RSP:
  - Capture tags and pending = dirty_i & valid_i.
  - Dirty-but-invalid ways are never written back.
  - If pending != 0 -> WB_REQ, else -> INV_REQ.
- WB_REQ:
  - wb_valid_o=1; wb_way_o = lowest set bit of pending.
  - wb_addr_o = {tag[wb_way_o], index, OFFSET_W'0}.
  - Outputs stable until wb_ready_i; handshake -> WB_WAIT.
- WB_WAIT:
  - On wb_done_i, clear that way's pending bit.
  - If remaining pending != 0 -> WB_REQ, else -> INV_REQ.
  - wb_done_i is ignored in all other states.
- INV_REQ: tag_req_o=1, tag_we_o=1, tag_way_be_o=all ones, tag_index_o=index. On grant:
  - index==NR_SETS-1 -> DONE.
  - Otherwise index+1 -> RD_REQ.
  - index never wraps within a flush.
- DONE: flush_ack_o=1 for exactly one cycle -> HOLD.
- HOLD: flush_i ignored for exactly one cycle, because the requester's registered request may still be high; then -> IDLE.
- flush_i deasserting mid-walk does not abort; the walk completes and acks.
- flush_i still high in IDLE after HOLD starts a new full flush.
- Timing with grants and writeback completing ideally: a clean set costs 3 cycles (RD_REQ, RD_RSP, INV_REQ); each dirty way adds 2 cycles (WB_REQ, WB_WAIT).

Test Plan:
- NR_SETS=4, NR_WAYS=2, all lines invalid, tag_gnt_i=1 always; flush_i high from cycle 0 -> exactly four reads and four invalidates, no wb_valid_o, flush_ack_o high in cycle 13 only, busy_o high cycles 1-14.
- Set 2 way 1 valid+dirty with tag 0x5A, wb_ready_i=1, wb_done_i one cycle after accept -> one writeback with wb_addr_o={0x5A,2'd2,4'h0}, wb_way_o=1; ack 2 cycles later than the clean case.
- Set 0 ways 0 and 1 both dirty -> way 0 written back first, then way 1; invalidate of set 0 issued only after second wb_done_i.
- Way dirty but not valid -> no writeback for that way.
- tag_gnt_i low for 5 cycles during RD_REQ and INV_REQ; wb_ready_i low for 3 cycles -> request outputs held stable, no skipped sets, single ack.
- flush_i held high through ack: no second flush starts until IDLE. Separately, assert rst_ni low while in WB_WAIT -> all outputs 0 next, no ack, returns to IDLE.
